// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer, clocked by the free-running reference clock.
//
// Holds the PLL in reset for RST_CYCLES, waits up to LOCK_TIMEOUT for lock with
// MAX_RETRIES extra attempts, then requires STABLE_CYCLES of continuous lock before
// releasing the system reset. Loss of lock in RUN restarts the whole sequence.
//
// Ports:
//   clk             reference clock (never a PLL output)
//   reset_n         asynchronous active-low reset
//   pll_locked      PLL lock indication, asynchronous to clk
//   force_relock    single-cycle request to restart the sequence
//   pll_rst         active-high PLL reset (RESET_PLL and FAIL)
//   sys_reset_n     registered active-low system reset, high only in RUN
//   pll_ready       high only in RUN
//   timeout_err     high only in FAIL
//   retry_count     timeouts seen in the current sequence
//   lock_loss_count saturating count of lock losses seen in RUN
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       pll_ready,
    output logic       timeout_err,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_e;

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]       MaxRetries  = 8'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             cnt_restart;
    logic             sync_q, locked_s;
    logic             sys_reset_n_q;

    // Two-flop synchronizer; only locked_s is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        loss_d      = loss_q;
        cnt_restart = 1'b0;

        unique case (state_q)
            StResetPll: begin
                if (force_relock) begin
                    cnt_restart = 1'b1;
                end else if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (!locked_s && (cnt_q == TimeoutLast)) begin
                    if (retry_q < MaxRetries) begin
                        retry_d = retry_q + 8'd1;
                        state_d = StResetPll;
                    end else begin
                        state_d = StFail;
                    end
                end else if (force_relock) begin
                    state_d = StResetPll;
                end else if (locked_s) begin
                    state_d = StStable;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (force_relock) begin
                    state_d = StResetPll;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    retry_d = 8'd0;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    if (loss_q != 8'hff) begin
                        loss_d = loss_q + 8'd1;
                    end
                    state_d = StResetPll;
                end else if (force_relock) begin
                    state_d = StResetPll;
                end
            end
            StFail: begin
                if (force_relock) begin
                    retry_d = 8'd0;
                    state_d = StResetPll;
                end
            end
            default: state_d = StResetPll;
        endcase

        // Counter restarts on any state change; it is idle in RUN and FAIL.
        if ((state_d != state_q) || cnt_restart) begin
            cnt_d = '0;
        end else if ((state_q == StRun) || (state_q == StFail)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StResetPll;
            cnt_q         <= '0;
            retry_q       <= 8'd0;
            loss_q        <= 8'd0;
            sys_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            // Dedicated flop so the system reset cannot glitch on state decode.
            sys_reset_n_q <= (state_d == StRun);
        end
    end

    assign pll_rst         = (state_q == StResetPll) || (state_q == StFail);
    assign pll_ready       = (state_q == StRun);
    assign timeout_err     = (state_q == StFail);
    assign sys_reset_n     = sys_reset_n_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule
